// File: rtl/ascon_pkg.sv
// Shared ASCON-AEAD128 widths, derived word counts and the result-return FSM encoding.
package ascon_pkg;

  localparam int ASCON_WORD_W = 32;
  localparam int ASCON_CT_W   = 384;
  localparam int ASCON_PT_W   = 256;
  localparam int ASCON_TAG_W  = 128;

  localparam int NW_CT = ASCON_CT_W / ASCON_WORD_W;
  localparam int NW_PT = ASCON_PT_W / ASCON_WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/ascon_result_tx.sv
// Captures the ASCON ciphertext+tag (and optionally plaintext) result and streams it
// MSB-first as WORD_W words over valid/ready; flags auth failure and result overrun.
module ascon_result_tx
  import ascon_pkg::*;
#(
  parameter int WORD_W  = ASCON_WORD_W,
  parameter int CT_W    = ASCON_CT_W,
  parameter int PT_W    = ASCON_PT_W,
  parameter int SEND_PT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [CT_W-1:0]   ct_in,
  input  logic [PT_W-1:0]   pt_in,
  input  logic              clr_status,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              auth_fail,
  output logic              overrun
);

  localparam int NWC  = CT_W / WORD_W;
  localparam int NWP  = PT_W / WORD_W;
  localparam int NW   = NWC + ((SEND_PT != 0) ? NWP : 0);
  localparam int FR_W = NW * WORD_W;
  localparam int IW   = $clog2(FR_W);

  tx_state_e       state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [FR_W-1:0] frame_q, frame_d, frame_cap;
  logic            auth_fail_q, auth_fail_d;
  logic            overrun_q, overrun_d;
  logic            done_q, done_d;
  logic            ov_set;
  logic            xfer;
  logic            at_last;
  logic [IW-1:0]   base;

  // One shadow holds the whole outgoing frame, so word selection is one part-select.
  if (SEND_PT != 0) begin : g_ct_pt
    assign frame_cap = {ct_in, pt_in};
  end else begin : g_ct_only
    assign frame_cap = ct_in;
  end

  assign at_last = (idx_q == 5'(NW - 1));
  assign xfer    = (state_q == SEND) && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    auth_fail_d = auth_fail_q;
    done_d      = 1'b0;
    ov_set      = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_valid) begin
          frame_d     = frame_cap;
          auth_fail_d = &pt_in;
          idx_d       = 5'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // A result arriving mid-frame (even on the final handshake) is dropped.
        ov_set = res_valid;
        if (xfer) begin
          if (at_last) begin
            state_d = IDLE;
            idx_d   = 5'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    overrun_d = ov_set ? 1'b1 : (clr_status ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      frame_q     <= '0;
      auth_fail_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      auth_fail_q <= auth_fail_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    base = IW'(FR_W - WORD_W - int'(idx_q) * WORD_W);
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = out_valid ? frame_q[base +: WORD_W] : '0;
  assign out_last  = out_valid && at_last;
  assign done      = done_q;
  assign auth_fail = auth_fail_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ascon_result_tx.sv
// Bench for ascon_result_tx: a ct+pt build and a ct-only build checked against a word-level model.
module tb_ascon_result_tx;
  import ascon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, res_valid, res_valid0, clr_status, out_ready;
  logic [383:0] ct_in;
  logic [255:0] pt_in;
  logic [31:0]  d1, d0;
  logic         v1, v0, l1, l0, b1, b0, dn1, dn0, af1, af0, ov1, ov0;

  int n_vec = 0;
  int n_err = 0;
  bit ov1_exp = 1'b0;

  ascon_result_tx #(.SEND_PT(1)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .ct_in(ct_in), .pt_in(pt_in),
    .clr_status(clr_status), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
    .out_last(l1), .busy(b1), .done(dn1), .auth_fail(af1), .overrun(ov1));

  ascon_result_tx #(.SEND_PT(0)) dut0 (
    .clk(clk), .rst(rst), .res_valid(res_valid0), .ct_in(ct_in), .pt_in(pt_in),
    .clr_status(clr_status), .out_data(d0), .out_valid(v0), .out_ready(out_ready),
    .out_last(l0), .busy(b0), .done(dn0), .auth_fail(af0), .overrun(ov0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word k of the frame: 12 ct words MSB first, then 8 pt words MSB first.
  function automatic logic [31:0] exp_word(input logic [383:0] ct, input logic [255:0] pt, input int k);
    if (k < 12) return 32'(ct >> (32 * (11 - k)));
    return 32'(pt >> (32 * (19 - k)));
  endfunction

  function automatic logic [383:0] rnd_ct();
    logic [383:0] r = '0;
    for (int i = 0; i < 12; i++) r = {r[351:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [255:0] rnd_pt();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  // mode: 0 = always ready, 1 = ready on odd cycles, 2 = random ready.
  // ov_at >= 0: pulse res_valid to the full build once while it shows word ov_at.
  task automatic run_frame(input logic [383:0] ct, input logic [255:0] pt, input int mode,
                           input int ov_at, input bit ov_clr);
    int k1 = 0, k0 = 0, c = 0, last_c = -1;
    bit pd1 = 0, pd0 = 0, fin1 = 0, fin0 = 0, pulsed = 0, hs1, hs0;
    @(negedge clk);
    ct_in = ct; pt_in = pt; res_valid = 1'b1; res_valid0 = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    res_valid = 1'b0; res_valid0 = 1'b0;
    ct_in = ~ct; pt_in = ~pt;  // shadow must hold the captured values
    chk("auth_fail", af1, 32'(&pt));
    chk("auth_fail_ct_only", af0, 32'(&pt));
    while (!(fin1 && fin0) && c < 200) begin
      chk("valid", v1, 32'(k1 < 20));
      chk("busy", b1, 32'(k1 < 20));
      chk("done", dn1, 32'(pd1));
      chk("overrun", ov1, 32'(ov1_exp));
      if (k1 < 20) begin
        chk("data", d1, exp_word(ct, pt, k1));
        chk("last", l1, 32'(k1 == 19));
      end
      chk("valid_ct_only", v0, 32'(k0 < 12));
      chk("done_ct_only", dn0, 32'(pd0));
      chk("overrun_ct_only", ov0, 32'd0);
      if (k0 < 12) begin
        chk("data_ct_only", d0, exp_word(ct, pt, k0));
        chk("last_ct_only", l0, 32'(k0 == 11));
      end
      out_ready  = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : 1'($urandom_range(0, 1));
      res_valid  = 1'b0;
      clr_status = 1'b0;
      if (ov_at >= 0 && !pulsed && k1 == ov_at) begin
        res_valid = 1'b1;
        pulsed    = 1'b1;
        ov1_exp   = 1'b1;
        if (ov_clr) clr_status = 1'b1;
      end
      hs1 = (k1 < 20) && out_ready;
      hs0 = (k0 < 12) && out_ready;
      pd1 = hs1 && (k1 == 19);
      pd0 = hs0 && (k0 == 11);
      if (pd1) last_c = c;
      if (hs1) k1++;
      if (hs0) k0++;
      fin1 = (k1 >= 20) && !pd1;
      fin0 = (k0 >= 12) && !pd0;
      @(negedge clk);
      c++;
    end
    res_valid = 1'b0; clr_status = 1'b0;
    if (c >= 200) chk("frame_timeout", 32'd1, 32'd0);
    if (mode == 1) chk("backpressure_cycles", 32'(last_c + 1), 32'd40);
    chk("auth_fail_hold", af1, 32'(&pt));
  endtask

  initial begin
    logic [383:0] ct_seq, ct_r;
    logic [255:0] pt_r;
    rst = 1'b1; res_valid = 1'b0; res_valid0 = 1'b0; clr_status = 1'b0; out_ready = 1'b0;
    ct_in = '0; pt_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", v1, 0); chk("rst_busy", b1, 0); chk("rst_done", dn1, 0);
    chk("rst_last", l1, 0); chk("rst_data", d1, 0); chk("rst_auth", af1, 0);
    chk("rst_overrun", ov1, 0); chk("rst_valid_ct_only", v0, 0);
    rst = 1'b0;

    for (int i = 0; i < 48; i++) ct_seq[383 - 8*i -: 8] = 8'(i);
    run_frame(ct_seq, '0, 0, -1, 0);
    run_frame(rnd_ct(), rnd_pt(), 1, -1, 0);
    run_frame(rnd_ct(), '1, 2, -1, 0);
    run_frame(rnd_ct(), rnd_pt(), 0, -1, 0);

    // Overrun mid-frame, then clear.
    run_frame(rnd_ct(), rnd_pt(), 0, 5, 0);
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0; ov1_exp = 1'b0;
    chk("overrun_cleared", ov1, 0);
    // Set and clear in the same cycle: set wins.
    run_frame(rnd_ct(), rnd_pt(), 2, 5, 1);
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0; ov1_exp = 1'b0;
    chk("overrun_cleared2", ov1, 0);
    // Result arriving on the final handshake is dropped and flags overrun.
    run_frame(rnd_ct(), rnd_pt(), 0, 19, 0);
    chk("dropped_no_restart", v1, 0);

    // Reset while the 7th word is on the bus.
    ct_r = rnd_ct(); pt_r = rnd_pt();
    @(negedge clk);
    ct_in = ct_r; pt_in = pt_r; res_valid = 1'b1; res_valid0 = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    res_valid = 1'b0; res_valid0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_word7", d1, exp_word(ct_r, pt_r, 6));
    rst = 1'b1;
    @(negedge clk);
    chk("reset_valid", v1, 0); chk("reset_busy", b1, 0);
    chk("reset_done", dn1, 0); chk("reset_overrun", ov1, 0);
    chk("reset_valid_ct_only", v0, 0);
    rst = 1'b0; ov1_exp = 1'b0;
    run_frame(rnd_ct(), rnd_pt(), 2, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
